// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the pipeline skid stage.
package pipe_pkg;

    localparam int PIPE_OCC_W = 2;

    // The encoding doubles as the occupancy count.
    typedef enum logic [PIPE_OCC_W-1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush and occupancy.
interface pipe_skid_stage_if import pipe_pkg::*; #(
    parameter int unsigned DATA_W = 16
);

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [PIPE_OCC_W-1:0] occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_skid_stage_data_reg.sv
// Payload register with write enable, async reset and synchronous clear to RESET_VAL.
module pipe_data_reg #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer; in_ready is a flop, flush squashes all entries.
module pipe_skid_stage import pipe_pkg::*; #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic              clk,
    input logic              rst,
    pipe_skid_stage_if.slave bus
);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic              in_ready_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_we;
    logic              main_from_skid;
    logic              skid_we;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        main_we        = 1'b0;
        main_from_skid = 1'b0;
        skid_we        = 1'b0;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d = ONE;
                        main_we = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_we = 1'b1;
                    end else if (in_xfer) begin
                        state_d = FULL;
                        skid_we = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_d        = ONE;
                        main_we        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is computed from the next state so upstream never sees a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign main_d = main_from_skid ? skid_q : bus.in_data;

    pipe_data_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .we  (main_we),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_data_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (bus.flush),
        .we  (skid_we),
        .d   (bus.in_data),
        .q   (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = main_q;
    assign bus.occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: directed scenarios plus randomized traffic against a FIFO model.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] RV = 16'h5A5A;

    logic clk;
    logic rst;

    pipe_skid_stage_if #(.DATA_W(DW)) bus ();

    pipe_skid_stage #(.DATA_W(DW), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    // Reference model: accepted entries in order, plus the model's view of held count and ready.
    logic [DW-1:0] sb_q[$];
    int            m_occ   = 0;
    bit            m_ready = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, compares against the model, then advances the model across the next edge.
    always @(negedge clk) begin
        bit in_x;
        bit out_x;
        if (rst) begin
            chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
            sb_q.delete();
            m_occ   = 0;
            m_ready = 1'b0;
        end else begin
            chk("in_ready",  32'(bus.in_ready),  32'(m_ready));
            chk("occupancy", 32'(bus.occupancy), 32'(m_occ));
            chk("out_valid", 32'(bus.out_valid), 32'(m_occ != 0));
            in_x  = bus.in_valid && m_ready;
            out_x = (m_occ != 0) && bus.out_ready;
            if (m_occ != 0) begin
                if (sb_q.size() == 0) begin
                    chk("out_data_model_empty", 32'(sb_q.size()), 32'd1);
                end else begin
                    chk("out_data", 32'(bus.out_data), 32'(sb_q[0]));
                    if (out_x) begin
                        void'(sb_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.flush) begin
                sb_q.delete();
                m_occ = 0;
            end else begin
                m_occ = m_occ + int'(in_x) - int'(out_x);
            end
            m_ready = (m_occ < 2);
        end
    end

    // Drive one cycle of stimulus; an entry the model says is accepted is pushed as expected output.
    task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #3;
        if (iv && m_ready && !rst) sb_q.push_back(d);
    endtask

    task automatic reset_pulse(input int cycles);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("async_rst_in_ready",  32'(bus.in_ready),  32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst          = 1'b0;
        // Offered on the first edge after release, which must not be accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("release_in_ready",  32'(bus.in_ready),  32'd1);
        chk("release_out_data",  32'(bus.out_data),  32'(RV));
        chk("release_occupancy", 32'(bus.occupancy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_data", 32'(bus.out_data), 32'(RV));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge_in_ready", 32'(bus.in_ready), 32'd1);

        // Zero-bubble streaming
        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Skid fill, hold with toggling input, then in-order drain
        step(1'b1, 16'hAAAA, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, (i % 2 == 0) ? 16'h1111 : 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_out_data",  32'(bus.out_data),  32'hAAAA);
        chk("hold_occupancy", 32'(bus.occupancy), 32'd2);
        base = n_out;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("drain_count", 32'(n_out - base), 32'd2);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Flush from FULL with an offered input
        step(1'b1, 16'h0A0A, 1'b0, 1'b0);
        step(1'b1, 16'h0B0B, 1'b0, 1'b0);
        step(1'b1, 16'hCCCC, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_occupancy", 32'(bus.occupancy), 32'd0);
        chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
        chk("flush_out_data",  32'(bus.out_data),  32'(RV));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with an output transfer
        step(1'b1, 16'hDDDD, 1'b0, 1'b0);
        base = n_out;
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("flush_out_count", 32'(n_out - base), 32'd1);
        chk("flush_out_empty", 32'(bus.occupancy), 32'd0);

        // Reset while FULL
        step(1'b1, 16'hE001, 1'b0, 1'b0);
        step(1'b1, 16'hE002, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        reset_pulse(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
